symfil_ctrl: RTL and testbench

- Sequencing controller for the slow symmetric FIR filter.
- Runs the coefficient-load sequence: holds the filter in reset, then streams NTAPS/2 taps from a host port.
- Paces incoming samples so filter i_ce pulses have at least GAP idle cycles between them.
- Captures each filter result into a one-entry valid/ready output buffer, discards the priming result and flags overruns.

---
 rtl/symfil_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_symfil_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symfil_ctrl.sv
// symfil_ctrl: sequencing controller for the slow symmetric FIR filter.
//
// Runs the coefficient-load sequence (hold filter in reset, flush, stream
// NTAPS/2 taps from the host), paces input samples so filter strobes are at
// least GAP idle cycles apart, and captures filter results into a one-entry
// valid/ready buffer. The first result after a load is the filter's stale
// accumulator and is discarded. A result arriving while the buffer is full
// and not being popped is dropped and flagged on a sticky overrun bit.
//
// Ports:
//   i_clk, i_reset_n                     clock, async active-low reset
//   i_cfg_start                          begin a coefficient reload (any state)
//   i_cfg_valid/o_cfg_ready, i_cfg_tap   host tap stream
//   o_cfg_busy                           flush or load in progress
//   i_s_valid/o_s_ready, i_s_data        sample stream
//   o_fil_reset                          synchronous reset to the filter
//   o_fil_tap_wr, o_fil_tap              filter tap write
//   o_fil_ce, o_fil_sample               filter sample strobe
//   i_fil_ce, i_fil_result               filter result strobe
//   o_r_valid/i_r_ready, o_r_data        result stream
//   o_overrun                            sticky: a result was dropped
module symfil_ctrl #(
    parameter int LGNTAPS  = 7,
    parameter int NTAPS    = 103,
    parameter int IW       = 16,
    parameter int TW       = 16,
    parameter int OW       = IW + TW + LGNTAPS,
    parameter int GAP      = NTAPS,
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cfg_start,
    input  logic          i_cfg_valid,
    output logic          o_cfg_ready,
    input  logic [TW-1:0] i_cfg_tap,
    output logic          o_cfg_busy,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    input  logic [IW-1:0] i_s_data,
    output logic          o_fil_reset,
    output logic          o_fil_tap_wr,
    output logic [TW-1:0] o_fil_tap,
    output logic          o_fil_ce,
    output logic [IW-1:0] o_fil_sample,
    input  logic          i_fil_ce,
    input  logic [OW-1:0] i_fil_result,
    output logic          o_r_valid,
    input  logic          i_r_ready,
    output logic [OW-1:0] o_r_data,
    output logic          o_overrun
);

    localparam int NLOAD = NTAPS >> 1;
    localparam int CW    = $clog2(NLOAD + 1);
    localparam int GW    = $clog2(GAP + 1);
    localparam logic [CW-1:0] NLOAD_M1 = CW'(NLOAD - 1);
    localparam logic [GW-1:0] GAP_L    = GW'(GAP);

    typedef enum logic [1:0] {S_HALT, S_FLUSH, S_LOAD, S_RUN} state_t;
    localparam state_t RESET_STATE = AUTO_RUN ? S_RUN : S_HALT;

    state_t        state, state_d;
    logic          flush_cnt, flush_cnt_d;
    logic [CW-1:0] tap_cnt, tap_cnt_d;
    logic [GW-1:0] gap, gap_d;
    logic          prime, prime_d;

    logic          cfg_ready_d, cfg_busy_d, s_ready_d, fil_reset_d;
    logic          fil_tap_wr_d, fil_ce_d, r_valid_d, overrun_d;
    logic [TW-1:0] fil_tap_d;
    logic [IW-1:0] fil_sample_d;
    logic [OW-1:0] r_data_d;

    logic cfg_hs, s_hs, pop, res_in;

    always_comb begin
        state_d      = state;
        flush_cnt_d  = flush_cnt;
        tap_cnt_d    = tap_cnt;
        gap_d        = gap;
        prime_d      = prime;
        r_valid_d    = o_r_valid;
        r_data_d     = o_r_data;
        overrun_d    = o_overrun;
        fil_tap_wr_d = 1'b0;
        fil_tap_d    = o_fil_tap;
        fil_ce_d     = 1'b0;
        fil_sample_d = o_fil_sample;

        cfg_hs = (state == S_LOAD) && o_cfg_ready && i_cfg_valid;
        s_hs   = (state == S_RUN) && o_s_ready && i_s_valid;
        pop    = o_r_valid && i_r_ready;
        res_in = (state == S_RUN) && i_fil_ce;

        if (i_cfg_start) begin
            // Reload wins over any handshake presented in the same cycle.
            state_d     = S_FLUSH;
            flush_cnt_d = 1'b0;
            tap_cnt_d   = '0;
            gap_d       = '0;
            prime_d     = 1'b1;
            r_valid_d   = 1'b0;
            r_data_d    = '0;
            overrun_d   = 1'b0;
        end else begin
            if (pop)
                r_valid_d = 1'b0;
            case (state)
                S_HALT: ;
                S_FLUSH: begin
                    // Two cycles of filter reset before taps are accepted.
                    if (flush_cnt)
                        state_d = S_LOAD;
                    else
                        flush_cnt_d = 1'b1;
                end
                S_LOAD: begin
                    if (cfg_hs) begin
                        fil_tap_wr_d = 1'b1;
                        fil_tap_d    = i_cfg_tap;
                        tap_cnt_d    = tap_cnt + 1'b1;
                        if (tap_cnt == NLOAD_M1)
                            state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (s_hs) begin
                        fil_ce_d     = 1'b1;
                        fil_sample_d = i_s_data;
                        gap_d        = GAP_L;
                    end else if (gap != '0) begin
                        gap_d = gap - 1'b1;
                    end
                    if (res_in) begin
                        // A same-cycle pop frees the slot for the new result.
                        if (prime)
                            prime_d = 1'b0;
                        else if (!o_r_valid || pop) begin
                            r_valid_d = 1'b1;
                            r_data_d  = i_fil_result;
                        end else
                            overrun_d = 1'b1;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end

        fil_reset_d = (state_d == S_HALT) || (state_d == S_FLUSH);
        cfg_busy_d  = (state_d == S_FLUSH) || (state_d == S_LOAD);
        cfg_ready_d = (state_d == S_LOAD);
        // Ready follows the gap counter one cycle late, so the sample strobes
        // end up GAP+2 cycles apart under continuous valid.
        s_ready_d   = (state_d == S_RUN) && (gap == '0) && !s_hs;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= RESET_STATE;
            flush_cnt    <= 1'b0;
            tap_cnt      <= '0;
            gap          <= '0;
            // With fixed taps the filter still emits one stale result first.
            prime        <= AUTO_RUN;
            o_fil_reset  <= !AUTO_RUN;
            o_cfg_busy   <= 1'b0;
            o_cfg_ready  <= 1'b0;
            o_s_ready    <= 1'b0;
            o_fil_tap_wr <= 1'b0;
            o_fil_tap    <= '0;
            o_fil_ce     <= 1'b0;
            o_fil_sample <= '0;
            o_r_valid    <= 1'b0;
            o_r_data     <= '0;
            o_overrun    <= 1'b0;
        end else begin
            state        <= state_d;
            flush_cnt    <= flush_cnt_d;
            tap_cnt      <= tap_cnt_d;
            gap          <= gap_d;
            prime        <= prime_d;
            o_fil_reset  <= fil_reset_d;
            o_cfg_busy   <= cfg_busy_d;
            o_cfg_ready  <= cfg_ready_d;
            o_s_ready    <= s_ready_d;
            o_fil_tap_wr <= fil_tap_wr_d;
            o_fil_tap    <= fil_tap_d;
            o_fil_ce     <= fil_ce_d;
            o_fil_sample <= fil_sample_d;
            o_r_valid    <= r_valid_d;
            o_r_data     <= r_data_d;
            o_overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_symfil_ctrl.sv
// Testbench for symfil_ctrl: drives the load, pacing and result paths with
// randomized stimulus and compares against a behavioural model.
module tb_symfil_ctrl;

    localparam int LGNTAPS = 7;
    localparam int NTAPS   = 103;
    localparam int IW      = 16;
    localparam int TW      = 16;
    localparam int OW      = IW + TW + LGNTAPS;
    localparam int GAP     = NTAPS;
    localparam int NLOAD   = NTAPS >> 1;

    logic          i_clk, i_reset_n;
    logic          i_cfg_start, i_cfg_valid, o_cfg_ready, o_cfg_busy;
    logic [TW-1:0] i_cfg_tap;
    logic          i_s_valid, o_s_ready;
    logic [IW-1:0] i_s_data;
    logic          o_fil_reset, o_fil_tap_wr, o_fil_ce;
    logic [TW-1:0] o_fil_tap;
    logic [IW-1:0] o_fil_sample;
    logic          i_fil_ce;
    logic [OW-1:0] i_fil_result;
    logic          o_r_valid, i_r_ready, o_overrun;
    logic [OW-1:0] o_r_data;

    symfil_ctrl #(
        .LGNTAPS(LGNTAPS), .NTAPS(NTAPS), .IW(IW), .TW(TW), .OW(OW),
        .GAP(GAP), .AUTO_RUN(1'b0)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cfg_start(i_cfg_start), .i_cfg_valid(i_cfg_valid),
        .o_cfg_ready(o_cfg_ready), .i_cfg_tap(i_cfg_tap), .o_cfg_busy(o_cfg_busy),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
        .o_fil_reset(o_fil_reset), .o_fil_tap_wr(o_fil_tap_wr), .o_fil_tap(o_fil_tap),
        .o_fil_ce(o_fil_ce), .o_fil_sample(o_fil_sample),
        .i_fil_ce(i_fil_ce), .i_fil_result(i_fil_result),
        .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_data(o_r_data),
        .o_overrun(o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [TW-1:0] tap_seen[$];
    logic [TW-1:0] exp_taps[$];
    int            ce_cyc[$];
    logic [IW-1:0] ce_smp[$];
    logic [IW-1:0] exp_smp[$];

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_fil_tap_wr) tap_seen.push_back(o_fil_tap);
            if (o_fil_ce) begin
                ce_cyc.push_back(cyc);
                ce_smp.push_back(o_fil_sample);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Streams n taps; handshake is taken whenever ready and valid coincide.
    task automatic load_taps(input int n, input bit rnd);
        logic [TW-1:0] tap;
        bit hs;
        int done;
        int budget;
        done = 0;
        budget = 0;
        while (done < n && budget < 1000) begin
            tap = rnd ? TW'($urandom) : TW'(done + 1);
            i_cfg_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_cfg_tap = tap;
            hs = o_cfg_ready && i_cfg_valid;
            tick();
            if (hs) begin
                exp_taps.push_back(tap);
                done++;
            end
            budget++;
        end
        i_cfg_valid = 1'b0;
        chk("load_count", done, n);
        if (!rnd) chk("load_b2b_cycles", budget, n);
    endtask

    task automatic check_taps(input string tag);
        chk({tag, "_n"}, tap_seen.size(), exp_taps.size());
        for (int i = 0; i < exp_taps.size() && i < tap_seen.size(); i++)
            chk(tag, tap_seen[i], exp_taps[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        bit            hs, exp_rdy, mprime, movr, pop, fce, rdy;
        int            last_e;
        logic [OW-1:0] res;
        logic [OW-1:0] mbuf[$];

        i_reset_n = 1'b0; i_cfg_start = 1'b0; i_cfg_valid = 1'b0; i_cfg_tap = '0;
        i_s_valid = 1'b0; i_s_data = '0; i_fil_ce = 1'b0; i_fil_result = '0;
        i_r_ready = 1'b0;
        last_e = 0;

        // ---- reset / halt ----
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_fil_reset", o_fil_reset, 1);
        chk("rst_s_ready", o_s_ready, 0);
        chk("rst_cfg_ready", o_cfg_ready, 0);
        chk("rst_r_valid", o_r_valid, 0);
        chk("rst_overrun", o_overrun, 0);
        i_reset_n = 1'b1;
        i_fil_ce = 1'b1; i_fil_result = 'h55;
        tick(); tick();
        i_fil_ce = 1'b0;
        chk("halt_fil_reset", o_fil_reset, 1);
        chk("halt_cfg_ready", o_cfg_ready, 0);
        chk("halt_busy", o_cfg_busy, 0);
        chk("halt_r_valid", o_r_valid, 0);

        // ---- flush ----
        i_cfg_start = 1'b1; tick(); i_cfg_start = 1'b0;
        chk("flush1_reset", o_fil_reset, 1);
        chk("flush1_busy", o_cfg_busy, 1);
        chk("flush1_ready", o_cfg_ready, 0);
        tick();
        chk("flush2_reset", o_fil_reset, 1);
        chk("flush2_ready", o_cfg_ready, 0);
        tick();
        chk("load_reset", o_fil_reset, 0);
        chk("load_ready", o_cfg_ready, 1);

        // ---- directed load 1..51 back-to-back ----
        tap_seen.delete(); exp_taps.delete();
        load_taps(NLOAD, 1'b0);
        chk("run_busy", o_cfg_busy, 0);
        chk("run_s_ready", o_s_ready, 1);
        chk("run_cfg_ready", o_cfg_ready, 0);
        tick();
        check_taps("tap_seq");

        // ---- ramp pacing ----
        ce_cyc.delete(); ce_smp.delete();
        i_s_valid = 1'b1; i_s_data = 1;
        for (int n = 0; n < 400 && ce_cyc.size() < 3; n++) begin
            hs = o_s_ready && i_s_valid;
            tick();
            if (hs) begin
                last_e = cyc;
                i_s_data = i_s_data + 1'b1;
            end
        end
        i_s_valid = 1'b0;
        chk("ramp_ce_single", o_fil_ce, 0);
        tick();
        chk("ramp_ce_count", ce_cyc.size(), 3);
        if (ce_cyc.size() >= 3) begin
            chk("ramp_spacing1", ce_cyc[1] - ce_cyc[0], GAP + 2);
            chk("ramp_spacing2", ce_cyc[2] - ce_cyc[1], GAP + 2);
            for (int i = 0; i < 3; i++) chk("ramp_sample", ce_smp[i], i + 1);
        end

        // ---- random pacing: ready returns GAP+1 edges after each accept ----
        ce_cyc.delete(); ce_smp.delete(); exp_smp.delete();
        for (int n = 0; n < 600; n++) begin
            i_s_valid = ($urandom_range(0, 7) == 0);
            i_s_data = IW'($urandom);
            exp_rdy = (cyc - last_e) >= GAP + 1;
            chk("pace_s_ready", o_s_ready, exp_rdy);
            hs = exp_rdy && i_s_valid;
            if (hs) exp_smp.push_back(i_s_data);
            tick();
            if (hs) last_e = cyc;
        end
        i_s_valid = 1'b0;
        tick();
        chk("pace_ce_n", ce_smp.size(), exp_smp.size());
        for (int i = 0; i < exp_smp.size() && i < ce_smp.size(); i++)
            chk("pace_sample", ce_smp[i], exp_smp[i]);

        // ---- directed result path ----
        i_r_ready = 1'b1;
        i_fil_ce = 1'b1; i_fil_result = '0; tick();
        chk("prime_discard", o_r_valid, 0);
        i_fil_result = 'h1234; tick();
        i_fil_ce = 1'b0;
        chk("res_valid", o_r_valid, 1);
        chk("res_data", o_r_data, 'h1234);
        tick();
        chk("res_popped", o_r_valid, 0);
        i_r_ready = 1'b0;
        i_fil_ce = 1'b1; i_fil_result = 'hA; tick();
        chk("full_a_data", o_r_data, 'hA);
        chk("full_a_ovr", o_overrun, 0);
        i_fil_result = 'hB; tick();
        chk("full_b_data", o_r_data, 'hA);
        chk("full_b_ovr", o_overrun, 1);
        i_fil_result = 'hC; tick();
        i_fil_ce = 1'b0;
        chk("full_c_data", o_r_data, 'hA);
        chk("full_c_valid", o_r_valid, 1);
        i_cfg_start = 1'b1; tick(); i_cfg_start = 1'b0;
        chk("start_clr_valid", o_r_valid, 0);
        chk("start_clr_ovr", o_overrun, 0);
        chk("start_s_ready", o_s_ready, 0);
        tick(); tick();
        chk("reload_ready", o_cfg_ready, 1);

        // ---- aborted load then full reload ----
        tap_seen.delete(); exp_taps.delete();
        load_taps(20, 1'b1);
        i_cfg_valid = 1'b1; i_cfg_tap = 'hDEAD; i_cfg_start = 1'b1;
        tick();
        i_cfg_start = 1'b0; i_cfg_valid = 1'b0;
        chk("abort_partial_n", tap_seen.size(), 20);
        tap_seen.delete(); exp_taps.delete();
        chk("abort_no_wr", o_fil_tap_wr, 0);
        chk("abort_flush1", o_fil_reset, 1);
        chk("abort_ready", o_cfg_ready, 0);
        i_fil_ce = 1'b1; i_fil_result = 'h777;
        tick();
        chk("abort_flush2", o_fil_reset, 1);
        i_fil_ce = 1'b0;
        tick();
        chk("abort_load", o_fil_reset, 0);
        chk("ignored_ce", o_r_valid, 0);
        load_taps(NLOAD, 1'b1);
        chk("reload_busy", o_cfg_busy, 0);
        chk("reload_s_ready", o_s_ready, 1);
        i_cfg_valid = 1'b1;
        tick(); tick(); tick();
        i_cfg_valid = 1'b0;
        check_taps("reload_tap");

        // ---- random result path against buffer model ----
        mprime = 1'b1; movr = 1'b0; mbuf.delete();
        for (int n = 0; n < 300; n++) begin
            fce = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            res = OW'({$urandom(), $urandom()});
            i_fil_ce = fce; i_r_ready = rdy; i_fil_result = res;
            pop = (mbuf.size() != 0) && rdy;
            if (pop) mbuf.delete();
            if (fce) begin
                if (mprime) mprime = 1'b0;
                else if (mbuf.size() == 0) mbuf.push_back(res);
                else movr = 1'b1;
            end
            tick();
            chk("rnd_valid", o_r_valid, mbuf.size() != 0);
            if (mbuf.size() != 0) chk("rnd_data", o_r_data, mbuf[0]);
            chk("rnd_overrun", o_overrun, movr);
        end
        i_fil_ce = 1'b0; i_r_ready = 1'b0;

        // ---- async reset mid-load ----
        i_cfg_start = 1'b1; tick(); i_cfg_start = 1'b0;
        tick(); tick();
        load_taps(10, 1'b1);
        chk("pre_reset_wr", o_fil_tap_wr, 1);
        #1 i_reset_n = 1'b0;
        #1;
        chk("async_wr", o_fil_tap_wr, 0);
        chk("async_fil_reset", o_fil_reset, 1);
        chk("async_busy", o_cfg_busy, 0);
        chk("async_ready", o_cfg_ready, 0);
        chk("async_valid", o_r_valid, 0);
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        tick(); tick();
        chk("post_halt_reset", o_fil_reset, 1);
        chk("post_halt_busy", o_cfg_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
